regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Write-side front end of the 32x32 register file. Merges two result sources onto the single register-file write port (WE, WrReg, InData):
  - the in-order pipeline writeback stage;
  - an out-of-order long-latency source (multiply/divide, load miss) with a valid/ready handshake.
- Buffers long-latency results in a small FIFO and exports a per-register pending mask to the hazard unit.
- Requests a pipeline bubble when buffered results are starved.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 4, long-latency result buffer entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive non-popped cycles with FIFO non-empty before wb_stall asserts

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  pipeline writeback valid; always accepted
- wb_reg  in  ADDR_WIDTH  pipeline destination register
- wb_data  in  DATA_WIDTH  pipeline result
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  long-latency result accepted when ll_valid&&ll_ready
- ll_reg  in  ADDR_WIDTH  long-latency destination register
- ll_data  in  DATA_WIDTH  long-latency result
- WE  out  1  register-file write enable (registered)
- WrReg  out  ADDR_WIDTH  register-file write index (registered)
- InData  out  DATA_WIDTH  register-file write data (registered)
- ll_pending  out  32  bit r set while a live FIFO entry targets register r
- wb_stall  out  1  request to upstream to insert a writeback bubble

Behaviour:
- Reset (async, immediate): WE=0, WrReg=0, InData=0, FIFO empty, all entries invalid, starve counter 0, wb_stall=0, ll_pending=0, ll_ready=1.
- Output timing: WE/WrReg/InData are registered at the rising edge and are stable for the whole following clock-high phase, which is when the register file writes. Latency from source to write port is 1 cycle.
- Register 0:
  - wb_valid with wb_reg=0 is treated as no write.
  - ll result with ll_reg=0 is handshaken (accepted) but not enqueued.
- Enqueue: ll_ready = !full, taken from registered occupancy. No same-cycle bypass around a full FIFO.
- Write-port selection, each cycle, in priority order:
  1. If wb_valid && wb_reg!=0, register {1, wb_reg, wb_data}.
  2. Else if FIFO non-empty: pop the head. If the head is live, register {1, head.reg, head.data}. If the head is killed, register WE=0 (the dead slot costs one cycle).
  3. Else register WE=0 with WrReg/InData held.
- WAW kill:
  - When a wb write to register r is selected, every valid FIFO entry with reg=r is marked killed in that cycle.
  - An ll entry enqueued in the same cycle with ll_reg=r is killed on entry; it is older by definition.
  - Killed entries are excluded from ll_pending.
- ll_pending: combinational OR of onehot(reg) over live FIFO entries. It includes entries enqueued at the previous edge and excludes entries popped at the previous edge.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and no pop occurs.
  - It clears on any pop or when the FIFO is empty.
  - wb_stall=1 (registered) while counter >= STARVE_LIMIT; it clears the cycle after a pop.
  - If wb_valid still arrives while wb_stall=1, wb still wins; correctness is preserved and only latency suffers.
- Simultaneous enqueue and pop: legal when not full. Occupancy is unchanged and pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all buffered results are discarded and WE drops to 0 immediately. Upstream must reissue.

Decomposition:
- Shared package `regfile_pkg`:
  - DATA_WIDTH, ADDR_WIDTH, ZERO_REG=0
  - typedef wb_entry_t {valid, killed, reg[ADDR_WIDTH], data[DATA_WIDTH]}
- One sub-module, `wb_result_fifo`:
  - circular buffer with push/pop, full/empty, a per-entry kill-by-register input, and a live-entry pending mask output.
  - The arbiter keeps the priority mux, the output registers and the starve counter.

Test Plan:
- Reset then wb_valid=1, wb_reg=5, wb_data=0x1234 -> next edge WE=1, WrReg=5, InData=0x1234; FIFO untouched; ll_pending=0.
- ll_valid with reg 7/0xAAAA, then reg 8/0xBBBB, while wb idle -> ll_pending bits 7,8 set after enqueue; writes emerge in order (7 then 8), one per cycle; ll_pending returns to 0.
- Fill FIFO (4 entries, regs 1-4) while wb_valid=1 every cycle to reg 9 -> ll_ready=0 after 4th accept; wb_stall rises after 8 starved cycles; dropping wb_valid drains 1,2,3,4 in order; wb_stall clears after the first pop.
- Enqueue ll reg 3/0x1, then wb reg 3/0x2 before the pop -> entry killed, ll_pending[3]=0; register 3 receives only 0x2; dead slot yields one cycle with WE=0.
- ll_valid reg 0 and wb_valid reg 0 in the same cycle -> ll_ready handshake completes; nothing enqueued; WE=0.
- Assert reset with 3 entries buffered and WE=1 -> WE, WrReg, InData go to 0 immediately; ll_pending=0; after release, ll_ready=1 and no stale writes appear.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared widths and the buffered-result record used by the register-file
// write arbiter and its long-latency result FIFO.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

    // One buffered long-latency result. 'killed' marks an entry superseded by
    // a younger pipeline write to the same register; it still occupies its slot
    // until popped but never reaches the register file.
    typedef struct packed {
        logic                  valid;
        logic                  killed;
        logic [ADDR_WIDTH-1:0] dst;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo
// Circular buffer of long-latency results waiting for the register-file
// write port.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   push/push_*       enqueue one entry (ignored when full)
//   push_killed       entry enters already killed
//   pop               dequeue head (ignored when empty)
//   kill_en/kill_reg  mark every valid entry targeting kill_reg as killed
//   full, empty       from registered occupancy
//   head              entry at the read pointer
//   pending           bit r set while a live (valid, not killed) entry targets r
module wb_result_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  push_killed,
    input  logic [ADDR_WIDTH-1:0] push_reg,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [ADDR_WIDTH-1:0] kill_reg,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t             head,
    output logic [NUM_REGS-1:0]   pending
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         entries_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              push_ok, pop_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entries_q[rd_ptr_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].valid && entries_q[i].dst == kill_reg)
                        entries_q[i].killed <= 1'b1;
                end
            end
            if (pop_ok) begin
                entries_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q <= rd_ptr_q + 1'b1;   // DEPTH is a power of two: natural wrap
            end
            // Push never targets the slot being popped: it only happens when not full.
            if (push_ok) begin
                entries_q[wr_ptr_q] <= '{valid: 1'b1, killed: push_killed,
                                         dst: push_reg, data: push_data};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && !entries_q[i].killed)
                pending[entries_q[i].dst] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Merges the in-order writeback stage and a buffered long-latency result
// stream onto the single register-file write port.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   wb_valid/wb_reg/wb_data   pipeline writeback, always accepted
//   ll_valid/ll_ready/ll_reg/ll_data  long-latency result handshake
//   WE/WrReg/InData           registered register-file write port
//   ll_pending                registers with a live buffered result
//   wb_stall                  registered request for a writeback bubble
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [ADDR_WIDTH-1:0] ll_reg,
    input  logic [DATA_WIDTH-1:0] ll_data,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] WrReg,
    output logic [DATA_WIDTH-1:0] InData,
    output logic [NUM_REGS-1:0]   ll_pending,
    output logic                  wb_stall
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                  full, empty;
    wb_entry_t             head;
    logic                  wb_sel, push, push_killed, pop;
    logic                  we_d, we_q;
    logic [ADDR_WIDTH-1:0] wrreg_d, wrreg_q;
    logic [DATA_WIDTH-1:0] indata_d, indata_q;
    logic [SW-1:0]         starve_d, starve_q;
    logic                  stall_q;

    // Writes to r0 are dropped; ll results to r0 still complete the handshake.
    assign wb_sel      = wb_valid && (wb_reg != ZERO_REG);
    assign ll_ready    = !full;
    assign push        = ll_valid && !full && (ll_reg != ZERO_REG);
    // An ll result arriving alongside a wb write to the same register is older.
    assign push_killed = wb_sel && (ll_reg == wb_reg);
    assign pop         = !wb_sel && !empty;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_killed(push_killed),
        .push_reg   (ll_reg),
        .push_data  (ll_data),
        .pop        (pop),
        .kill_en    (wb_sel),
        .kill_reg   (wb_reg),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .pending    (ll_pending)
    );

    always_comb begin
        we_d     = 1'b0;
        wrreg_d  = wrreg_q;
        indata_d = indata_q;
        if (wb_sel) begin
            we_d     = 1'b1;
            wrreg_d  = wb_reg;
            indata_d = wb_data;
        end else if (pop && !head.killed) begin
            we_d     = 1'b1;
            wrreg_d  = head.dst;
            indata_d = head.data;
        end
    end

    // Saturating count of cycles the buffer waited without draining.
    always_comb begin
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            wrreg_q  <= '0;
            indata_q <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            wrreg_q  <= wrreg_d;
            indata_q <= indata_d;
            starve_q <= starve_d;
            stall_q  <= (starve_d >= SW'(STARVE_LIMIT));
        end
    end

    assign WE       = we_q;
    assign WrReg    = wrreg_q;
    assign InData   = indata_q;
    assign wb_stall = stall_q;

endmodule
